// File: rtl/nsa_pkg.sv
// nsa_pkg -- shared definitions for the nibble-serial adder sequencer.
//   nsa_state_e : sequencer state (IDLE, RUN, DONE)
//   SLICE_W     : width of the single time-multiplexed adder slice
package nsa_pkg;

  localparam int SLICE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } nsa_state_e;

endpackage

// File: rtl/nibble_adder.sv
// nibble_adder -- combinational SLICE_W-bit ripple-carry adder built from
// per-bit full adders.
//   a, b : slice operands
//   cin  : carry into bit 0
//   sum  : slice sum
//   cout : carry out of the top bit
module nibble_adder
  import nsa_pkg::*;
(
  input  logic [SLICE_W-1:0] a,
  input  logic [SLICE_W-1:0] b,
  input  logic               cin,
  output logic [SLICE_W-1:0] sum,
  output logic               cout
);

  logic [SLICE_W:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < SLICE_W; i++) begin : g_fa
    assign sum[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i + 1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  assign cout = c[SLICE_W];

endmodule

// File: rtl/nibble_serial_adder_ctrl.sv
// nibble_serial_adder_ctrl -- adds two WIDTH-bit operands one nibble per
// clock through a single nibble_adder slice, LSB nibble first, chaining the
// carry through a register.
//
// Ports:
//   clk, rst_n          : clock, synchronous active-low reset
//   in_valid / in_ready : operand handshake (a, b, cin)
//   out_valid/out_ready : result handshake (sum, cout)
//   busy                : high while an operation is in RUN or DONE
//   sub                 : subtract select, present only with ADD_SUB_EN
//
// Handshake semantics: a transfer happens on a rising clk edge where both
// valid and ready are high. in_ready is high only in IDLE; out_valid is
// high only in DONE, where sum/cout are held until out_ready is seen. Valid
// or ready asserted outside those states has no effect.
//
// Build option: define ADD_SUB_EN to add the sub input. With sub=1 the
// block computes a-b (b inverted per slice, carry seeded with 1, cin
// ignored); cout=1 then means no borrow.
module nibble_serial_adder_ctrl
  import nsa_pkg::*;
#(
  parameter int WIDTH = 16  // multiple of SLICE_W, at least SLICE_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef ADD_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);

  localparam int NSLICE = WIDTH / SLICE_W;
  localparam int CNT_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [CNT_W-1:0] LAST_SLICE = CNT_W'(NSLICE - 1);

  nsa_state_e       state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
`ifdef ADD_SUB_EN
  logic             sub_q, sub_d;
`endif

  logic [SLICE_W-1:0] a_sl, b_sl, b_eff, slice_sum;
  logic               slice_cout;

  // Pick the nibble addressed by the slice counter.
  always_comb begin
    a_sl = '0;
    b_sl = '0;
    for (int i = 0; i < NSLICE; i++) begin
      if (cnt_q == CNT_W'(i)) begin
        a_sl = a_q[i*SLICE_W +: SLICE_W];
        b_sl = b_q[i*SLICE_W +: SLICE_W];
      end
    end
`ifdef ADD_SUB_EN
    b_eff = sub_q ? ~b_sl : b_sl;
`else
    b_eff = b_sl;
`endif
  end

  nibble_adder u_slice (
    .a    (a_sl),
    .b    (b_eff),
    .cin  (carry_q),
    .sum  (slice_sum),
    .cout (slice_cout)
  );

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    cnt_d   = cnt_q;
`ifdef ADD_SUB_EN
    sub_d   = sub_q;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid && in_ready) begin
          a_d     = a;
          b_d     = b;
          carry_d = cin;
          cnt_d   = '0;
`ifdef ADD_SUB_EN
          sub_d   = sub;
          // Two's-complement subtract: the +1 replaces cin.
          if (sub) carry_d = 1'b1;
`endif
          state_d = RUN;
        end
      end
      RUN: begin
        for (int i = 0; i < NSLICE; i++) begin
          if (cnt_q == CNT_W'(i)) sum_d[i*SLICE_W +: SLICE_W] = slice_sum;
        end
        carry_d = slice_cout;
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_SLICE) begin
          cout_d  = slice_cout;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      cnt_q   <= '0;
`ifdef ADD_SUB_EN
      sub_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      cnt_q   <= cnt_d;
`ifdef ADD_SUB_EN
      sub_q   <= sub_d;
`endif
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign sum       = sum_q;
  assign cout      = cout_q;

endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// tb_nibble_serial_adder_ctrl -- scoreboard bench for nibble_serial_adder_ctrl
// (WIDTH=16). Define ADD_SUB_EN to also exercise the subtract path.
module tb_nibble_serial_adder_ctrl;

  localparam int WIDTH  = 16;
  localparam int NSLICE = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] a = '0;
  logic [WIDTH-1:0] b = '0;
  logic             cin = 1'b0;
`ifdef ADD_SUB_EN
  logic             sub = 1'b0;
`endif
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             busy;

  nibble_serial_adder_ctrl #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
`ifdef ADD_SUB_EN
    .sub       (sub),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .busy      (busy)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  logic [WIDTH:0] exp_q[$];
  int             acc_q[$];
  int             n_checks = 0;
  int             n_fail = 0;
  int             n_pushed = 0;
  int             n_popped = 0;
  bit             rand_ordy = 1'b0;
  bit             ordy_val = 1'b1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic logic [WIDTH:0] model(input logic [WIDTH-1:0] ma, input logic [WIDTH-1:0] mb,
                                           input logic mc, input logic ms);
    if (ms) return {1'b0, ma} + {1'b0, ~mb} + 17'd1;
    return {1'b0, ma} + {1'b0, mb} + {16'd0, mc};
  endfunction

  // out_ready driver: changes just after the active edge.
  always @(posedge clk) begin
    #1;
    out_ready = rand_ordy ? ($urandom_range(0, 3) != 0) : ordy_val;
  end

  // ---------------- monitor ----------------
  logic prev_valid = 1'b0;
  always @(negedge clk) begin
    if (out_valid && !prev_valid) begin
      if (acc_q.size() == 0) check("spurious_valid", 32'(out_valid), 32'd0);
      else check("latency", 32'(cyc - acc_q.pop_front()), 32'(NSLICE));
    end
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) check("extra_result", 32'(out_valid & out_ready), 32'd0);
      else begin
        n_popped++;
        check("result", 32'({cout, sum}), 32'(exp_q.pop_front()));
      end
    end
    prev_valid = out_valid;
  end

  // ---------------- driver tasks ----------------
  // Presents one operation; if keep, pushes its expected {cout,sum}.
  task automatic issue(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb,
                       input logic tc, input logic ts, input bit keep,
                       input logic [WIDTH:0] texp);
    int guard = 0;
    @(negedge clk);
    while (!in_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 200) begin
      check("in_ready_timeout", 32'(in_ready), 32'd1);
      return;
    end
    a = ta;
    b = tb;
    cin = tc;
`ifdef ADD_SUB_EN
    sub = ts;
`else
    if (ts) $display("note: subtract request ignored in add-only build");
`endif
    in_valid = 1'b1;
    if (keep) begin
      exp_q.push_back(texp);
      acc_q.push_back(cyc + 1);
      n_pushed++;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int guard = 0;
    @(negedge clk);
    while ((exp_q.size() != 0 || !in_ready) && guard < 500) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 500) check("drain_timeout", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_sum"}, 32'(sum), 32'd0);
    check({tag, "_cout"}, 32'(cout), 32'd0);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #5_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- main sequence ----------------
  initial begin
    int guard;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_idle_outputs("reset");
    rst_n = 1'b1;
    ordy_val = 1'b1;

    // Directed additions with hand-computed results {cout,sum}.
    issue(16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b1, 17'h10000); drain();
    issue(16'h0000, 16'h0000, 1'b1, 1'b0, 1'b1, 17'h00001); drain();
    issue(16'h8000, 16'h8000, 1'b0, 1'b0, 1'b1, 17'h10000); drain();
    issue(16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 1'b1, 17'h1FFFF); drain();
    issue(16'h0FFF, 16'h0001, 1'b0, 1'b0, 1'b1, 17'h01000); drain();

    // Consumer stall: result held stable, no new acceptance.
    ordy_val = 1'b0;
    issue(16'h1234, 16'h4321, 1'b1, 1'b0, 1'b1, 17'h05556);
    guard = 0;
    while (!out_valid && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    check("stall_reach_done", 32'(out_valid), 32'd1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_out_valid", 32'(out_valid), 32'd1);
      check("stall_sum", 32'({cout, sum}), 32'h05556);
      check("stall_in_ready", 32'(in_ready), 32'd0);
    end
    ordy_val = 1'b1;
    guard = 0;
    while (out_valid && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    check("release_in_ready", 32'(in_ready), 32'd1);
    check("release_busy", 32'(busy), 32'd0);

    // Operand changes and in_valid pulses while busy are ignored.
    issue(16'h00F0, 16'h0F0F, 1'b0, 1'b0, 1'b1, 17'h00FFF);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("busy_in_ready", 32'(in_ready), 32'd0);
      a = 16'($urandom);
      b = 16'($urandom);
      cin = 1'b1;
      in_valid = 1'b1;
    end
    @(negedge clk);
    in_valid = 1'b0;
    drain();

    // Reset on the second RUN cycle aborts the operation.
    issue(16'hAAAA, 16'h5555, 1'b0, 1'b0, 1'b0, 17'h0);
    @(negedge clk);
    check("abort_busy_run", 32'(busy), 32'd1);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check_idle_outputs("abort");
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("abort_no_valid", 32'(out_valid), 32'd0);
    end

`ifdef ADD_SUB_EN
    issue(16'h0005, 16'h0007, 1'b0, 1'b1, 1'b1, 17'h0FFFE); drain();
    issue(16'h0007, 16'h0005, 1'b0, 1'b1, 1'b1, 17'h10002); drain();
    issue(16'h0007, 16'h0005, 1'b1, 1'b1, 1'b1, 17'h10002); drain();
    issue(16'h1234, 16'h1234, 1'b0, 1'b1, 1'b1, 17'h10000); drain();
    issue(16'h0007, 16'h0005, 1'b1, 1'b0, 1'b1, 17'h0000D); drain();
`endif

    // Randomised operations with producer gaps and consumer stalls.
    rand_ordy = 1'b1;
    for (int n = 0; n < 1000; n++) begin
      logic [WIDTH-1:0] ra, rb;
      logic             rc, rs;
      ra = 16'($urandom);
      rb = 16'($urandom);
      rc = 1'($urandom_range(0, 1));
`ifdef ADD_SUB_EN
      rs = 1'($urandom_range(0, 1));
`else
      rs = 1'b0;
`endif
      repeat ($urandom_range(0, 3)) @(negedge clk);
      issue(ra, rb, rc, rs, 1'b1, model(ra, rb, rc, rs));
    end
    drain();
    rand_ordy = 1'b0;
    repeat (3) @(negedge clk);

    check("results_count", 32'(n_popped), 32'(n_pushed));
    check("final_idle", 32'(in_ready), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
